lsu_mem_ctrl: RTL

Parametrised load/store unit for the rv32i memory stage. It replaces the fixed single-cycle memory wrapper with a registered request/grant/response interface to data memory and supports wait states. It generates byte enables and lane-replicated store data, and it sign- or zero-extends load data. Illegal func3 codes, misaligned accesses and memory timeouts are reported as errors. It sits between the execute stage and the data memory (or bus bridge).

---
 rtl/lsu_mem_ctrl_if.sv | 41 ++++
 rtl/lsu_mem_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// Bus bundle for the load/store unit: pipeline-side access handshake plus the
// request/grant/response channel to data memory.
// master = the LSU itself, slave = its environment (pipeline + memory).
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 14
);
    // Pipeline side
    logic              core_valid;
    logic              core_ready;
    logic              core_we;
    logic [2:0]        func3;
    logic [ADDR_W-1:0] core_addr;
    logic [31:0]       core_wdata;
    logic              core_done;
    logic              core_err;
    logic [31:0]       core_rdata;

    // Memory side
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        input  core_valid, core_we, func3, core_addr, core_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output core_ready, core_done, core_err, core_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        output core_valid, core_we, func3, core_addr, core_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  core_ready, core_done, core_err, core_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// rv32i load/store unit: one access in flight, registered request/grant/
// response to data memory with wait states, byte-lane steering, load
// extension and error reporting (illegal func3, misalignment, timeout).
module lsu_mem_ctrl #(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 0,
    parameter int TO_W    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    lsu_mem_ctrl_if.master  bus
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam bit            TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT - 1) : '0;

    state_t            r_state;
    logic              r_we;
    logic [2:0]        r_f3;
    logic [1:0]        r_off;
    logic [TO_W-1:0]   r_cnt;

    logic              r_done;
    logic              r_err;
    logic [31:0]       r_rdata;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [3:0]        r_mem_be;
    logic [ADDR_W-3:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;

    logic              w_legal;
    logic              w_aligned;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_ldata;
    logic              w_expire;

    // Decode the incoming access: legality, alignment, lane enables, store data
    always_comb begin
        w_legal   = 1'b0;
        w_aligned = 1'b1;
        w_be      = 4'b1111;
        w_wdata   = bus.core_wdata;
        case (bus.func3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = ~bus.core_we;  // LBU/LHU have no store twin
            default:                w_legal = 1'b0;
        endcase
        case (bus.func3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << bus.core_addr[1:0];
                w_wdata = {4{bus.core_wdata[7:0]}};
            end
            2'b01: begin
                w_aligned = ~bus.core_addr[0];
                w_be      = 4'b0011 << bus.core_addr[1:0];
                w_wdata   = {2{bus.core_wdata[15:0]}};
            end
            default: begin
                w_aligned = (bus.core_addr[1:0] == 2'b00);
                w_be      = 4'b1111;
                w_wdata   = bus.core_wdata;
            end
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it
    always_comb begin
        w_byte = 8'h00;
        case (r_off)
            2'd0:    w_byte = bus.mem_rdata[7:0];
            2'd1:    w_byte = bus.mem_rdata[15:8];
            2'd2:    w_byte = bus.mem_rdata[23:16];
            default: w_byte = bus.mem_rdata[31:24];
        endcase
        w_half = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (r_f3)
            3'b000:  w_ldata = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ldata = {24'h000000, w_byte};
            3'b001:  w_ldata = {{16{w_half[15]}}, w_half};
            3'b101:  w_ldata = {16'h0000, w_half};
            default: w_ldata = bus.mem_rdata;
        endcase
    end

    // Last permitted REQ/WAIT cycle; a gnt/rvalid in this same cycle still wins
    assign w_expire = TO_EN && (r_cnt == TO_LAST);

    // Access sequencer: all core/memory outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_f3        <= 3'b000;
            r_off       <= 2'b00;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= 32'h0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'b0000;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.core_valid) begin
                        r_we  <= bus.core_we;
                        r_f3  <= bus.func3;
                        r_off <= bus.core_addr[1:0];
                        r_cnt <= '0;
                        if (w_legal && w_aligned) begin
                            r_state     <= S_REQ;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= bus.core_we;
                            r_mem_be    <= w_be;
                            r_mem_addr  <= bus.core_addr[ADDR_W-1:2];
                            r_mem_wdata <= w_wdata;
                        end else begin
                            // Rejected before touching memory
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                            r_rdata <= 32'h0;
                        end
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (bus.mem_gnt) begin
                        r_mem_req <= 1'b0;
                        if (r_we) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b0;
                            r_rdata <= 32'h0;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else if (w_expire) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                        r_rdata   <= 32'h0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (bus.mem_rvalid) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b0;
                        r_rdata <= w_ldata;
                    end else if (w_expire) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_rdata <= 32'h0;
                    end
                end
                S_DONE: begin
                    // core_rdata is left alone so it holds until the next completion
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.core_ready = (r_state == S_IDLE);
    assign bus.core_done  = r_done;
    assign bus.core_err   = r_err;
    assign bus.core_rdata = r_rdata;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_be     = r_mem_be;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;

endmodule
